// File: rtl/normalizer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : normalizer_pkg
// Description : Shared constants and types for the normalizer memory agent:
//               data width, the poison word returned for bad reads, and the
//               read-pipeline stage record.
// Revision    : 1.0 - initial release
// ============================================================================
package normalizer_pkg;

   localparam int DATA_W = 32;

   // Returned with readdatavalid for any read whose address fails decode
   localparam logic [DATA_W-1:0] POISON = 32'hDEAD_BEEF;

   typedef logic [DATA_W-1:0] word_t;

   // One slot of the read-response pipeline
   typedef struct packed {
      logic  valid;
      logic  poison;
      word_t data;
   } rd_stage_t;

endpackage
`default_nettype wire

// File: rtl/normalizer_mem_ram.sv
`default_nettype none
// ============================================================================
// Module      : normalizer_mem_ram
// Description : Single-port synchronous RAM, one-cycle registered read,
//               write-first when read and write hit the same cycle. The read
//               register only updates on a read enable so its value is stable
//               between reads. Contents are never reset.
// Revision    : 1.0 - initial release
// ============================================================================
module normalizer_mem_ram
   import normalizer_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
)(
   input  logic          clk,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  word_t         wdata,
   output word_t         rdata
);

   word_t r_mem [0:DEPTH-1];
   word_t r_rdata;

   // Storage write and registered read; a simultaneous write forwards its data
   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[addr] <= wdata;
      end
      if (re) begin
         r_rdata <= we ? wdata : r_mem[addr];
      end
   end

   assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/normalizer_mem_agent.sv
`default_nettype none
// ============================================================================
// Module      : normalizer_mem_agent
// Description : Avalon-MM responder serving the normalizer DMA masters.
//               Pipelined reads with fixed latency READ_LAT, outstanding-read
//               throttling through waitrequest, address decode with poison
//               responses, and a sticky error flag with first-address capture.
// Revision    : 1.0 - initial release
// ============================================================================
module normalizer_mem_agent
   import normalizer_pkg::*;
#(
   parameter int          DEPTH       = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          READ_LAT    = 2,
   parameter int          MAX_PENDING = 4
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] avs_s1_address,
   input  logic        avs_s1_read,
   input  logic        avs_s1_write,
   input  word_t       avs_s1_writedata,
   output logic        avs_s1_waitrequest,
   output logic        avs_s1_readdatavalid,
   output word_t       avs_s1_readdata,
   input  logic        stall_in,
   input  logic        err_clr,
   output logic        err_flag,
   output logic [31:0] err_addr
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [32:0] SPAN     = 33'(DEPTH) << 2;
   localparam logic [3:0]  PEND_MAX = 4'(MAX_PENDING);

   // ------------------------------------------------------------------
   // Address decode
   // ------------------------------------------------------------------
   // 33-bit difference: an address below BASE_ADDR borrows into bit 32 and
   // therefore compares as larger than SPAN, so one compare covers both bounds.
   logic [32:0]   w_offset;
   logic          w_addr_ok;
   logic [AW-1:0] w_index;

   assign w_offset  = {1'b0, avs_s1_address} - {1'b0, BASE_ADDR};
   assign w_addr_ok = (w_offset < SPAN) && (avs_s1_address[1:0] == 2'b00);
   assign w_index   = w_offset[AW+1:2];

   // ------------------------------------------------------------------
   // Command handshake
   // ------------------------------------------------------------------
   logic       w_retire;
   logic       w_full;
   logic       w_rd_only;
   logic       w_wait;
   logic       w_accept;
   logic       w_wr_acc;
   logic       w_rd_acc;
   logic       w_err_ev;
   logic [3:0] r_outstanding;

   // A read+write pair is a write, and writes must never be throttled, so the
   // pending-limit term only looks at pure reads.
   assign w_rd_only = avs_s1_read & ~avs_s1_write;
   assign w_full    = (r_outstanding == PEND_MAX);
   assign w_wait    = rst | stall_in | (w_rd_only & w_full & ~w_retire);
   assign w_accept  = (avs_s1_read | avs_s1_write) & ~w_wait;
   assign w_wr_acc  = w_accept & avs_s1_write;
   assign w_rd_acc  = w_accept & w_rd_only;
   assign w_err_ev  = w_accept & ((avs_s1_read & avs_s1_write) | ~w_addr_ok);

   assign avs_s1_waitrequest = w_wait;

   // Outstanding-read counter: +1 on read acceptance, -1 on response, hold on both
   always_ff @(posedge clk) begin
      if (rst) begin
         r_outstanding <= 4'd0;
      end else begin
         case ({w_rd_acc, w_retire})
            2'b10:   r_outstanding <= r_outstanding + 4'd1;
            2'b01:   r_outstanding <= r_outstanding - 4'd1;
            default: r_outstanding <= r_outstanding;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Storage
   // ------------------------------------------------------------------
   word_t w_ram_rdata;

   normalizer_mem_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (w_wr_acc & w_addr_ok),
      .re    (w_rd_acc & w_addr_ok),
      .addr  (w_index),
      .wdata (avs_s1_writedata),
      .rdata (w_ram_rdata)
   );

   // ------------------------------------------------------------------
   // Read-response pipeline
   // ------------------------------------------------------------------
   // Stage 1 is the RAM read register plus these tags; invalid reads do not
   // touch the RAM and are replaced by POISON at the pipeline output.
   logic      r_s1_valid;
   logic      r_s1_poison;
   rd_stage_t w_s1;
   rd_stage_t w_last;

   // First-stage tags travel alongside the RAM read register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid  <= 1'b0;
         r_s1_poison <= 1'b0;
      end else begin
         r_s1_valid <= w_rd_acc;
         if (w_rd_acc) begin
            r_s1_poison <= ~w_addr_ok;
         end
      end
   end

   assign w_s1 = '{valid: r_s1_valid, poison: r_s1_poison, data: w_ram_rdata};

   generate
      if (READ_LAT == 1) begin : g_lat_one
         assign w_last = w_s1;
      end else begin : g_lat_pipe
         rd_stage_t r_pipe [0:READ_LAT-2];

         // Remaining READ_LAT-1 stages; reset empties every slot
         always_ff @(posedge clk) begin
            if (rst) begin
               for (int i = 0; i < READ_LAT-1; i++) begin
                  r_pipe[i] <= '0;
               end
            end else begin
               r_pipe[0] <= w_s1;
               for (int i = 1; i < READ_LAT-1; i++) begin
                  r_pipe[i] <= r_pipe[i-1];
               end
            end
         end

         assign w_last = r_pipe[READ_LAT-2];
      end
   endgenerate

   assign w_retire = w_last.valid;

   // ------------------------------------------------------------------
   // Response output with hold
   // ------------------------------------------------------------------
   word_t w_last_word;
   word_t w_rdata_core;
   word_t r_hold_data;

   assign w_last_word  = w_last.poison ? POISON : w_last.data;
   assign w_rdata_core = w_last.valid ? w_last_word : r_hold_data;

   // Remember the last presented response so readdata holds while idle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hold_data <= '0;
      end else begin
         r_hold_data <= w_rdata_core;
      end
   end

   // Reset masks the outputs immediately so an in-flight read can never
   // surface in the reset cycle itself.
   assign avs_s1_readdatavalid = w_last.valid & ~rst;
   assign avs_s1_readdata      = rst ? '0 : w_rdata_core;

   // ------------------------------------------------------------------
   // Error tracking
   // ------------------------------------------------------------------
   logic        r_err_flag;
   logic [31:0] r_err_addr;

   // Sticky error; a new error outranks a simultaneous clear and re-captures
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err_flag <= 1'b0;
         r_err_addr <= 32'd0;
      end else if (w_err_ev) begin
         r_err_flag <= 1'b1;
         if (~r_err_flag | err_clr) begin
            r_err_addr <= avs_s1_address;
         end
      end else if (err_clr) begin
         r_err_flag <= 1'b0;
         r_err_addr <= 32'd0;
      end
   end

   assign err_flag = r_err_flag;
   assign err_addr = r_err_addr;

endmodule
`default_nettype wire

// File: tb/tb_normalizer_mem_agent.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_normalizer_mem_agent
// Description : Self-checking bench for normalizer_mem_agent. A cycle monitor
//               compares every output against a queue/array reference model;
//               a vector table and hand sequences cover decode, latency,
//               errors, reset and throttling corners.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_normalizer_mem_agent;

   localparam int          DEPTH = 1024;
   localparam logic [31:0] BASE  = 32'h0001_0000;
   localparam int          LAT   = 2;
   localparam int          MAXP  = 4;
   localparam logic [31:0] POIS  = 32'hDEAD_BEEF;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Main instance signals
   logic [31:0] cmd_addr  = '0;
   logic        cmd_rd    = 1'b0;
   logic        cmd_wr    = 1'b0;
   logic [31:0] cmd_wdata = '0;
   logic        stall     = 1'b0;
   logic        clr       = 1'b0;
   logic        wreq;
   logic        rdv;
   logic [31:0] rdata;
   logic        eflag;
   logic [31:0] eaddr;

   // Second instance (MAX_PENDING = 1)
   logic [31:0] a1     = '0;
   logic        rd1    = 1'b0;
   logic        wr1    = 1'b0;
   logic [31:0] wd1    = '0;
   logic        stall1 = 1'b0;
   logic        clr1   = 1'b0;
   logic        wait1;
   logic        rdv1;
   logic [31:0] rdata1;
   logic        ef1;
   logic [31:0] ea1;

   normalizer_mem_agent #(
      .DEPTH(DEPTH), .BASE_ADDR(BASE), .READ_LAT(LAT), .MAX_PENDING(MAXP)
   ) u_dut (
      .clk(clk), .rst(rst),
      .avs_s1_address(cmd_addr), .avs_s1_read(cmd_rd), .avs_s1_write(cmd_wr),
      .avs_s1_writedata(cmd_wdata), .avs_s1_waitrequest(wreq),
      .avs_s1_readdatavalid(rdv), .avs_s1_readdata(rdata),
      .stall_in(stall), .err_clr(clr), .err_flag(eflag), .err_addr(eaddr)
   );

   normalizer_mem_agent #(
      .DEPTH(DEPTH), .BASE_ADDR(BASE), .READ_LAT(LAT), .MAX_PENDING(1)
   ) u_dut1 (
      .clk(clk), .rst(rst),
      .avs_s1_address(a1), .avs_s1_read(rd1), .avs_s1_write(wr1),
      .avs_s1_writedata(wd1), .avs_s1_waitrequest(wait1),
      .avs_s1_readdatavalid(rdv1), .avs_s1_readdata(rdata1),
      .stall_in(stall1), .err_clr(clr1), .err_flag(ef1), .err_addr(ea1)
   );

   // ------------------------------------------------------------------
   // Check bookkeeping
   // ------------------------------------------------------------------
   int n_total = 0;
   int n_pass  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic timeout_fail(input string name);
      n_total++;
      $display("FAIL %s: bound expired at %0t", name, $time);
   endtask

   // ------------------------------------------------------------------
   // Reference model: word array, queue of expected responses, error state
   // ------------------------------------------------------------------
   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_rd_t;

   exp_rd_t     pq[$];
   logic [31:0] mmem [DEPTH];
   logic [31:0] last_rd = '0;
   bit          m_flag  = 1'b0;
   logic [31:0] m_addr  = '0;
   int          cyc = 0;
   bit          mon_on = 1'b0;
   int          resp_count = 0;
   int          last_resp_cyc = 0;
   int          last_acc_cyc = 0;
   logic [31:0] last_resp = '0;
   logic [31:0] resp_log[$];

   function automatic bit addr_ok(input logic [31:0] a);
      longint ua = longint'(a);
      return (ua >= longint'(BASE)) && (ua < longint'(BASE) + 4 * DEPTH) && (ua % 4 == 0);
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   task automatic monitor_step();
      int          pend;
      bit          retire;
      bit          exp_wait;
      bit          ok;
      bit          err_ev;
      int          idx;
      exp_rd_t     e;
      check("err_flag", 32'(eflag), 32'(m_flag));
      check("err_addr", eaddr, m_addr);
      if (rst) begin
         check("rst_waitrequest", 32'(wreq), 32'd1);
         check("rst_readdatavalid", 32'(rdv), 32'd0);
         check("rst_readdata", rdata, 32'd0);
         pq.delete();
         last_rd = '0;
         m_flag  = 1'b0;
         m_addr  = '0;
      end else begin
         pend   = pq.size();
         retire = (pend > 0) && (pq[0].due == cyc);
         check("readdatavalid", 32'(rdv), 32'(retire));
         if (retire) begin
            e = pq.pop_front();
            check("readdata", rdata, e.data);
            last_rd = e.data;
            resp_count++;
            last_resp = rdata;
            last_resp_cyc = cyc;
            resp_log.push_back(rdata);
         end else begin
            check("readdata_hold", rdata, last_rd);
         end
         exp_wait = stall || (cmd_rd && !cmd_wr && pend == MAXP && !retire);
         check("waitrequest", 32'(wreq), 32'(exp_wait));
         err_ev = 1'b0;
         if ((cmd_rd || cmd_wr) && !exp_wait) begin
            last_acc_cyc = cyc;
            ok  = addr_ok(cmd_addr);
            idx = ok ? int'((cmd_addr - BASE) >> 2) : 0;
            if (cmd_wr) begin
               if (ok) mmem[idx] = cmd_wdata;
            end else begin
               pq.push_back('{data: (ok ? mmem[idx] : POIS), due: cyc + LAT});
            end
            err_ev = (cmd_rd && cmd_wr) || !ok;
         end
         if (err_ev) begin
            if (!m_flag || clr) m_addr = cmd_addr;
            m_flag = 1'b1;
         end else if (clr) begin
            m_flag = 1'b0;
            m_addr = '0;
         end
      end
   endtask

   always @(negedge clk) if (mon_on) monitor_step();

   // Response capture for the MAX_PENDING=1 instance
   logic [31:0] q1[$];
   always @(negedge clk) if (!rst && rdv1) q1.push_back(rdata1);

   // Pseudo-random backpressure
   bit stall_en = 1'b0;
   initial begin
      forever begin
         @(posedge clk);
         #1;
         stall = stall_en ? ($urandom_range(0, 2) == 0) : 1'b0;
      end
   end

   // Watchdog
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------
   // Drive helpers (called at posedge+1)
   // ------------------------------------------------------------------
   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_cmd(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
      bit w;
      int n;
      n = 0;
      cmd_rd = rd; cmd_wr = wr; cmd_addr = a; cmd_wdata = d;
      do begin
         @(negedge clk);
         w = wreq;
         @(posedge clk);
         #1;
         n++;
      end while (w && n < 100);
      if (w) timeout_fail("cmd_accept");
      cmd_rd = 1'b0; cmd_wr = 1'b0;
   endtask

   task automatic wait_resp(input int target);
      int n;
      n = 0;
      while (resp_count < target && n < 30) begin
         wait_cycles(1);
         n++;
      end
      if (resp_count < target) timeout_fail("resp_wait");
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      wait_cycles(1);
      clr = 1'b0;
   endtask

   // ------------------------------------------------------------------
   // Test sequence
   // ------------------------------------------------------------------
   typedef struct {
      bit          do_wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      bit          exp_err;
   } vec_t;

   vec_t        tbl[9];
   logic [31:0] sdata[256];

   initial begin
      int          rc;
      int          acc;
      int          k;
      int          j;
      int          r;
      bit          w;
      logic [31:0] a;

      tbl[0] = '{1'b1, BASE + 32'h10,   32'h1234_5678, 32'h1234_5678, 1'b0};
      tbl[1] = '{1'b1, BASE,            32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0};
      tbl[2] = '{1'b1, BASE + 32'hFFC,  32'hCAFE_BABE, 32'hCAFE_BABE, 1'b0};
      tbl[3] = '{1'b1, BASE + 32'h1000, 32'h1111_1111, POIS,          1'b1};
      tbl[4] = '{1'b1, BASE + 32'h2,    32'h2222_2222, POIS,          1'b1};
      tbl[5] = '{1'b1, BASE - 32'h4,    32'h3333_3333, POIS,          1'b1};
      tbl[6] = '{1'b1, 32'hFFFF_FFFC,   32'h4444_4444, POIS,          1'b1};
      tbl[7] = '{1'b0, BASE,            32'h0,         32'h0BAD_F00D, 1'b0};
      tbl[8] = '{1'b0, BASE + 32'hFFC,  32'h0,         32'hCAFE_BABE, 1'b0};

      // Reset state
      @(posedge clk);
      #1;
      mon_on = 1'b1;
      @(negedge clk);
      check("reset_waitrequest", 32'(wreq), 32'd1);
      check("reset_readdatavalid", 32'(rdv), 32'd0);
      check("reset_readdata", rdata, 32'd0);
      check("reset_err_flag", 32'(eflag), 32'd0);
      check("reset_err_addr", eaddr, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      wait_cycles(1);

      // MAX_PENDING=1: alternate waitrequest, in-order responses
      for (int i = 0; i < 8; i++) begin
         wr1 = 1'b1; a1 = BASE + 32'(4 * i); wd1 = 32'hB000_0000 + 32'(i);
         @(negedge clk);
         check("dut1_write_wait", 32'(wait1), 32'd0);
         @(posedge clk);
         #1;
      end
      wr1 = 1'b0;
      rd1 = 1'b1; a1 = BASE; k = 0; j = 0;
      while (k < 8 && j < 40) begin
         @(negedge clk);
         check("dut1_wait_alternate", 32'(wait1), 32'(j % 2));
         w = wait1;
         @(posedge clk);
         #1;
         if (!w) begin
            k++;
            a1 = BASE + 32'(4 * k);
         end
         j++;
      end
      rd1 = 1'b0;
      wait_cycles(6);
      check("dut1_resp_count", 32'(q1.size()), 32'd8);
      for (int i = 0; i < 8 && i < q1.size(); i++)
         check("dut1_resp_data", q1[i], 32'hB000_0000 + 32'(i));

      // Vector table: write, read next cycle, latency, data, error
      for (int i = 0; i < 9; i++) begin
         pulse_clr();
         if (tbl[i].do_wr) do_cmd(1'b0, 1'b1, tbl[i].addr, tbl[i].wdata);
         rc = resp_count;
         do_cmd(1'b1, 1'b0, tbl[i].addr, 32'h0);
         acc = last_acc_cyc;
         wait_resp(rc + 1);
         check("tbl_rdata", last_resp, tbl[i].exp_rdata);
         check("tbl_latency", 32'(last_resp_cyc - acc), 32'(LAT));
         check("tbl_err_flag", 32'(eflag), 32'(tbl[i].exp_err));
      end

      // Two invalid reads back to back: first address captured
      pulse_clr();
      rc = resp_count;
      do_cmd(1'b1, 1'b0, BASE + 32'h1000, 32'h0);
      do_cmd(1'b1, 1'b0, BASE + 32'h2, 32'h0);
      wait_resp(rc + 2);
      check("bad_rd_poison0", resp_log[resp_log.size()-2], POIS);
      check("bad_rd_poison1", resp_log[resp_log.size()-1], POIS);
      check("bad_rd_err_flag", 32'(eflag), 32'd1);
      check("bad_rd_err_addr", eaddr, BASE + 32'h1000);

      // Error coinciding with err_clr wins and re-captures
      clr = 1'b1;
      do_cmd(1'b1, 1'b0, BASE + 32'h1001, 32'h0);
      clr = 1'b0;
      wait_cycles(3);
      check("clr_race_flag", 32'(eflag), 32'd1);
      check("clr_race_addr", eaddr, BASE + 32'h1001);
      pulse_clr();
      wait_cycles(1);
      check("clr_flag", 32'(eflag), 32'd0);
      check("clr_addr", eaddr, 32'd0);

      // Read and write together: write only, no response, error
      rc = resp_count;
      do_cmd(1'b1, 1'b1, BASE, 32'hA5A5_A5A5);
      wait_cycles(6);
      check("rw_no_resp", 32'(resp_count), 32'(rc));
      check("rw_err_flag", 32'(eflag), 32'd1);
      check("rw_err_addr", eaddr, BASE);
      do_cmd(1'b1, 1'b0, BASE, 32'h0);
      wait_resp(rc + 1);
      check("rw_mem", last_resp, 32'hA5A5_A5A5);
      pulse_clr();
      wait_cycles(1);
      check("rw_clr_flag", 32'(eflag), 32'd0);

      // Reset with two reads in flight
      do_cmd(1'b1, 1'b0, BASE + 32'h10, 32'h0);
      do_cmd(1'b1, 1'b0, BASE + 32'hFFC, 32'h0);
      rst = 1'b1;
      rc = resp_count;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("rst_mid_wait", 32'(wreq), 32'd1);
         check("rst_mid_rdv", 32'(rdv), 32'd0);
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      wait_cycles(8);
      check("rst_no_resp", 32'(resp_count), 32'(rc));
      do_cmd(1'b1, 1'b0, BASE + 32'h10, 32'h0);
      wait_resp(rc + 1);
      check("rst_ram_kept", last_resp, 32'h1234_5678);

      // 256-word DMA-style stream under random backpressure
      stall_en = 1'b1;
      for (int i = 0; i < 256; i++) begin
         sdata[i] = $urandom;
         do_cmd(1'b0, 1'b1, BASE + 32'h400 + 32'(4 * i), sdata[i]);
      end
      resp_log.delete();
      rc = resp_count;
      for (int i = 0; i < 256; i++)
         do_cmd(1'b1, 1'b0, BASE + 32'h400 + 32'(4 * i), 32'h0);
      wait_resp(rc + 256);
      check("stream_count", 32'(resp_log.size()), 32'd256);
      for (int i = 0; i < 256 && i < resp_log.size(); i++)
         check("stream_data", resp_log[i], sdata[i]);

      // Random mixed traffic, all checked by the monitor model
      for (int i = 0; i < 200; i++) begin
         r = int'($urandom_range(0, 99));
         a = BASE + 32'h400 + 32'(4 * $urandom_range(0, 255));
         if ($urandom_range(0, 9) == 0) begin
            case ($urandom_range(0, 2))
               0:       a = BASE + 32'h1000 + 32'(4 * $urandom_range(0, 15));
               1:       a = a + 32'($urandom_range(1, 3));
               default: a = BASE - 32'(4 * $urandom_range(1, 4));
            endcase
         end
         clr = ($urandom_range(0, 19) == 0);
         if (r < 45)      do_cmd(1'b1, 1'b0, a, 32'h0);
         else if (r < 85) do_cmd(1'b0, 1'b1, a, $urandom);
         else if (r < 90) do_cmd(1'b1, 1'b1, a, $urandom);
         else             wait_cycles(1);
         clr = 1'b0;
      end
      stall_en = 1'b0;
      wait_cycles(10);
      check("drain_empty", 32'(pq.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/normalizer_mem_agent.md
NORMALIZER_MEM_AGENT -- requirements
Module: normalizer_mem_agent

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, RAM size in 32-bit words (power of two).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0.
REQ-003 SHALL have parameter READ_LAT, default 2, cycles from read acceptance to readdatavalid (range 1..8).
REQ-004 SHALL have parameter MAX_PENDING, default 4, maximum outstanding reads (range 1..15).
REQ-005 SHALL have port clk, input, 1: the single clock.
REQ-006 SHALL have port rst, input, 1: reset, synchronous to clk and active-high.
REQ-007 SHALL have port avs_s1_address, input, 32: byte address.
REQ-008 SHALL have port avs_s1_read, input, 1: read request.
REQ-009 SHALL have port avs_s1_write, input, 1: write request.
REQ-010 SHALL have port avs_s1_writedata, input, 32: write data.
REQ-011 SHALL have port avs_s1_waitrequest, output, 1: command stall.
REQ-012 SHALL have port avs_s1_readdatavalid, output, 1: read response strobe.
REQ-013 SHALL have port avs_s1_readdata, output, 32: read response data.
REQ-014 SHALL have port stall_in, input, 1: forces waitrequest for backpressure injection.
REQ-015 SHALL have port err_clr, input, 1: clears error state.
REQ-016 SHALL have port err_flag, output, 1: sticky address/protocol error.
REQ-017 SHALL have port err_addr, output, 32: first offending address.

Function
REQ-018 SHALL be the Avalon-MM responder serving the normalizer DMA masters (pipelined reads, variable latency, waitrequest).
REQ-019 SHALL accept a command in a cycle where (read|write) and waitrequest is low.
REQ-020 SHALL drive waitrequest combinationally as rst | stall_in | (read & outstanding==MAX_PENDING & no response retiring in the same cycle).
REQ-021 SHALL never assert waitrequest for writes, except under rst or stall_in.
REQ-022 SHALL treat an address as valid iff address >= BASE_ADDR, address < BASE_ADDR+4*DEPTH, and address[1:0]==0; the word index is (address-BASE_ADDR)>>2.
REQ-023 SHALL commit an accepted valid write to RAM at the acceptance edge; an invalid write is dropped.
REQ-024 SHALL pulse readdatavalid for exactly one cycle per accepted read, exactly READ_LAT cycles after acceptance, in acceptance order; back-to-back reads SHALL give back-to-back responses.
REQ-025 SHALL return RAM contents for a valid read, and 32'hDEAD_BEEF (POISON) with readdatavalid for an invalid read.
REQ-026 SHALL return the new data for a read accepted in the cycle after a write to the same address.
REQ-027 SHALL hold readdata at its last value when readdatavalid is low.
REQ-028 SHALL increment the outstanding counter on read acceptance, decrement it on readdatavalid, and leave it unchanged when both occur.
REQ-029 SHALL treat read and write asserted together as a write only, with no read response, and set err_flag.
REQ-030 SHALL set err_flag on any invalid accepted address; err_addr SHALL capture the address only when err_flag was previously clear.
REQ-031 SHALL clear err_flag and err_addr on err_clr; an error in the same cycle as err_clr SHALL win and set/capture.

Reset
REQ-032 SHALL, under rst, set waitrequest=1, readdatavalid=0, readdata=0, err_flag=0, err_addr=0, outstanding=0, and flush the read pipeline.
REQ-033 SHALL discard in-flight reads when rst is asserted mid-operation, producing no readdatavalid after reset release.
REQ-034 SHALL NOT clear RAM contents on rst.

Structure
REQ-035 SHALL take the 32-bit data width constant and the POISON value from shared package normalizer_pkg.
REQ-036 SHALL instantiate one sub-module normalizer_mem_ram: single-port synchronous RAM with 1-cycle read and write-first behaviour.
REQ-037 SHALL realise the remaining READ_LAT-1 stages as a valid/data/poison shift register.

Verification
REQ-038 Write 0x1234_5678 to BASE+0x10, then read it the next cycle -> readdatavalid exactly 2 cycles after acceptance, data 0x1234_5678.
REQ-039 Issue 8 back-to-back reads with MAX_PENDING=1 -> waitrequest alternates, 8 in-order responses, outstanding never exceeds 1.
REQ-040 Read BASE+4*DEPTH and BASE+0x2 -> POISON returned twice, err_flag=1, err_addr = BASE+4*DEPTH.
REQ-041 Assert read and write together at BASE+0 with 0xA5A5_A5A5 -> no response, memory holds 0xA5A5_A5A5, err_flag=1; then err_clr -> err_flag=0.
REQ-042 Assert rst one cycle after 2 reads are accepted -> zero readdatavalid pulses afterwards, waitrequest=1 during rst; RAM contents retained.
REQ-043 Toggle stall_in pseudo-randomly during a 256-word DMA-style stream -> all data matches and no commands are lost or duplicated.
